// File: rtl/lcd_tile_transposer.sv
// Tile transposer between a row-major bitmap ROM and the LCD controller.
// Fetches one 8x8 tile (8 row bytes) per request and hands out the 8 column
// bytes (bit0 = top pixel) one per falling edge of the LCD enable.
module lcd_tile_transposer #(
  parameter int unsigned ADDR_W   = 6,
  parameter bit          MSB_LEFT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_request_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              en_i,
  output logic              data_ack_o,
  output logic [7:0]        data_o,
  output logic [ADDR_W+2:0] rom_addr_o,
  output logic              rom_en_o,
  input  logic [7:0]        rom_data_i
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StReady,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0][7:0]     rows_q, rows_d;
  logic                en_q;
  logic                data_ack_q, data_ack_d;
  logic [7:0]          data_q, data_d;
  logic [ADDR_W+2:0]   rom_addr_q, rom_addr_d;
  logic                rom_en_q, rom_en_d;
  logic                consume;

  // Column k gathers pixel k of every row; bit r comes from row r.
  function automatic logic [7:0] column(input logic [7:0][7:0] rows, input logic [2:0] k);
    logic [7:0] col;
    col = '0;
    for (int r = 0; r < 8; r++) begin
      col[r] = MSB_LEFT ? rows[r][3'd7 - k] : rows[r][k];
    end
    return col;
  endfunction

  assign consume = en_q & ~en_i;

  // Next-state, fetch sequencing and byte hand-out.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rows_d     = rows_q;
    data_ack_d = data_ack_q;
    data_d     = data_q;
    rom_addr_d = rom_addr_q;
    rom_en_d   = rom_en_q;

    unique case (state_q)
      StIdle: begin
        if (data_request_i) begin
          addr_d     = address_i;
          cnt_d      = 3'd0;
          rom_en_d   = 1'b1;
          rom_addr_d = {address_i, 3'd0};
          state_d    = StFetch;
        end
      end
      StFetch: begin
        if (!data_request_i) begin
          state_d    = StIdle;
          data_ack_d = 1'b0;
          rom_en_d   = 1'b0;
          idx_d      = 3'd0;
        end else begin
          // ROM data lags the strobe by one cycle, so row c-1 lands now.
          if (cnt_q != 3'd0) begin
            rows_d[cnt_q - 3'd1] = rom_data_i;
          end
          if (cnt_q == 3'd7) begin
            rom_en_d = 1'b0;
            state_d  = StDrain;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            rom_addr_d = {addr_q, cnt_q + 3'd1};
          end
        end
      end
      StDrain: begin
        if (!data_request_i) begin
          state_d    = StIdle;
          data_ack_d = 1'b0;
          rom_en_d   = 1'b0;
          idx_d      = 3'd0;
        end else begin
          rows_d[7]  = rom_data_i;
          data_d     = column(rows_d, 3'd0);
          data_ack_d = 1'b1;
          idx_d      = 3'd0;
          state_d    = StReady;
        end
      end
      StReady: begin
        // An abort wins over a coincident consume.
        if (!data_request_i) begin
          state_d    = StIdle;
          data_ack_d = 1'b0;
          rom_en_d   = 1'b0;
          idx_d      = 3'd0;
        end else if (consume) begin
          if (idx_q == 3'd7) begin
            data_ack_d = 1'b0;
            idx_d      = 3'd0;
            state_d    = StDone;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = column(rows_q, idx_q + 3'd1);
          end
        end
      end
      StDone: begin
        // Held request must not re-trigger; wait for it to drop.
        if (!data_request_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= 3'd0;
      idx_q      <= 3'd0;
      rows_q     <= '0;
      en_q       <= 1'b0;
      data_ack_q <= 1'b0;
      data_q     <= 8'h00;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rows_q     <= rows_d;
      en_q       <= en_i;
      data_ack_q <= data_ack_d;
      data_q     <= data_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q   <= rom_en_d;
    end
  end

  assign data_ack_o = data_ack_q;
  assign data_o     = data_q;
  assign rom_addr_o = rom_addr_q;
  assign rom_en_o   = rom_en_q;

endmodule
